// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between the serial line / bus control stage and
// the UART receiver.
//   rx          : serial line, idle high, 8N1, LSB first (asynchronous)
//   data_rx     : last correctly framed byte
//   done_rx     : one-cycle pulse, data_rx just updated with a new byte
//   active_rx   : high while a frame is being received
//   frame_error : one-cycle pulse, stop bit sampled low
// Modports:
//   master : receiver side (consumes rx, drives the result signals)
//   slave  : line driver / consumer side
interface uart_rx_if;
    logic       rx;
    logic [7:0] data_rx;
    logic       done_rx;
    logic       active_rx;
    logic       frame_error;

    modport master (
        input  rx,
        output data_rx,
        output done_rx,
        output active_rx,
        output frame_error
    );

    modport slave (
        output rx,
        input  data_rx,
        input  done_rx,
        input  active_rx,
        input  frame_error
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   CLKS_PER_BIT : clock cycles per serial bit (4..65535)
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high
//   bus          : uart_rx_if.master (rx in; data_rx, done_rx, active_rx,
//                  frame_error out)
// The line passes through a 2-flop synchronizer; every decision uses the
// synchronized value rx_s. A low stop bit reports a frame error and parks the
// receiver in BREAK until the line returns high, so a held-low line never
// yields a second frame.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic      clock,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state, state_next;
    logic        rx_meta, rx_s;
    logic [15:0] cnt, cnt_next;
    logic [2:0]  idx, idx_next;
    logic [7:0]  shreg, shreg_next;
    logic [7:0]  data_q, data_next;
    logic        done_q, done_next;
    logic        ferr_q, ferr_next;

    // Synchronizer resets to the idle level so reset never looks like a start.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            idx    <= idx_next;
            shreg  <= shreg_next;
            data_q <= data_next;
            done_q <= done_next;
            ferr_q <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        data_next  = data_q;
        done_next  = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end

            // Re-check the start bit at its centre; a short low glitch
            // falls back to IDLE without touching any output.
            START: begin
                if (cnt == HALF_CNT) begin
                    if (!rx_s) begin
                        state_next = DATA;
                        cnt_next   = '0;
                        idx_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            // Counting a full bit period from the start-bit centre lands
            // every sample in the middle of its data bit.
            DATA: begin
                if (cnt == LAST_CNT) begin
                    shreg_next[idx] = rx_s;
                    cnt_next        = '0;
                    if (idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            // Stop bit is judged at its centre, leaving half a bit of slack
            // to catch the next start edge from IDLE.
            STOP: begin
                if (cnt == LAST_CNT) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        data_next  = shreg;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end

            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.data_rx     = data_q;
    assign bus.done_rx     = done_q;
    assign bus.frame_error = ferr_q;
    assign bus.active_rx   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// Frames are driven bit by bit from a directed sequence with random bytes
// and gaps; a monitor records every done_rx pulse (value and time) and every
// frame_error cycle, and the sequence compares these against the bytes it
// sent, the expected mid-bit latency and the framing rules.
module tb_uart_rx;

    localparam int N    = 16;
    localparam int HALF = (N - 1) / 2;
    localparam int LAT  = 2 + HALF + 9 * N;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_data[$];
    longint     got_t[$];
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         spurious = 0;
    logic [7:0] prev_data;

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clock) begin
        if (bus.done_rx === 1'b1) begin
            got_data.push_back(bus.data_rx);
            got_t.push_back(longint'($time));
        end
        if (bus.frame_error === 1'b1) ferr_cnt++;
        if (bus.done_rx === 1'b1 && bus.frame_error === 1'b1) both_cnt++;
        if (!reset && bus.done_rx !== 1'b1 && bus.data_rx !== prev_data) spurious++;
        prev_data = bus.data_rx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives a full frame starting at a falling clock edge; returns the time
    // the start bit began.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output longint t_fall);
        t_fall = longint'($time);
        bus.rx = 1'b0;
        repeat (N) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (N) @(negedge clock);
        end
        bus.rx = stop_bit;
        repeat (N) @(negedge clock);
    endtask

    // Expects exactly one recorded frame carrying byte b, with its done pulse
    // within one cycle of the nominal latency from the start edge.
    task automatic expect_frame(input string tag, input logic [7:0] b, input longint t_fall);
        longint lat;
        check({tag, "_count"}, got_data.size(), 1);
        if (got_data.size() > 0) begin
            // rx changes on a falling edge; the first rising edge to see it
            // is half a period later, as is the pulse's rising edge.
            lat = (got_t[0] - t_fall - 10) / 10;
            check({tag, "_data"}, got_data[0], b);
            check({tag, "_latency"}, (lat >= LAT - 1 && lat <= LAT + 1), 1);
            void'(got_data.pop_front());
            void'(got_t.pop_front());
        end
    endtask

    initial begin
        logic [7:0] model_data;
        logic [7:0] b;
        logic [7:0] part;
        longint     t1, t2;
        int         ferr_before;

        model_data = 8'h00;
        bus.rx     = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_data", bus.data_rx, 8'h00);
        check("rst_done", bus.done_rx, 1'b0);
        check("rst_active", bus.active_rx, 1'b0);
        check("rst_ferr", bus.frame_error, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Single valid frame
        send_frame(8'hA5, 1'b1, t1);
        repeat (10) @(negedge clock);
        expect_frame("a5", 8'hA5, t1);
        model_data = 8'hA5;
        check("a5_out", bus.data_rx, model_data);
        check("a5_active_after", bus.active_rx, 1'b0);
        check("a5_no_ferr", ferr_cnt, 0);

        // Random bytes with random idle gaps
        for (int k = 0; k < 5; k++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 20)) @(negedge clock);
            send_frame(b, 1'b1, t1);
            repeat (5) @(negedge clock);
            expect_frame("rand", b, t1);
            model_data = b;
            check("rand_out", bus.data_rx, model_data);
            check("rand_idle", bus.active_rx, 1'b0);
        end
        check("rand_no_ferr", ferr_cnt, 0);

        // Back-to-back frames with no idle gap
        send_frame(8'h3C, 1'b1, t1);
        send_frame(8'hC3, 1'b1, t2);
        repeat (10) @(negedge clock);
        check("b2b_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("b2b_first", got_data[0], 8'h3C);
            check("b2b_second", got_data[1], 8'hC3);
            check("b2b_spacing", 32'((got_t[1] - got_t[0]) / 10), 160);
        end
        got_data.delete();
        got_t.delete();
        model_data = 8'hC3;
        check("b2b_out", bus.data_rx, model_data);

        // Short low glitch is rejected
        bus.rx = 1'b0;
        repeat (5) @(negedge clock);
        bus.rx = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_no_done", got_data.size(), 0);
        check("glitch_no_ferr", ferr_cnt, 0);
        check("glitch_idle", bus.active_rx, 1'b0);
        check("glitch_data", bus.data_rx, model_data);

        // Low stop bit followed by a held-low line
        ferr_before = ferr_cnt;
        send_frame(8'h55, 1'b0, t1);
        repeat (100) @(negedge clock);
        check("ferr_pulse", ferr_cnt, ferr_before + 1);
        check("ferr_no_done", got_data.size(), 0);
        check("ferr_data_kept", bus.data_rx, model_data);
        check("ferr_break_active", bus.active_rx, 1'b1);
        bus.rx = 1'b1;
        repeat (10) @(negedge clock);
        check("ferr_released_idle", bus.active_rx, 1'b0);
        check("ferr_no_second", ferr_cnt, ferr_before + 1);
        check("ferr_still_no_done", got_data.size(), 0);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, t1);
        repeat (5) @(negedge clock);
        expect_frame("recover", b, t1);
        model_data = b;

        // Reset during bit 4 abandons the frame
        part = 8'hA5;
        bus.rx = 1'b0;
        repeat (N) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            bus.rx = part[i];
            repeat (N) @(negedge clock);
        end
        bus.rx = part[4];
        repeat (N / 2) @(negedge clock);
        check("mid_active", bus.active_rx, 1'b1);
        reset  = 1'b1;
        bus.rx = 1'b1;
        @(negedge clock);
        model_data = 8'h00;
        check("mrst_data", bus.data_rx, model_data);
        check("mrst_done", bus.done_rx, 1'b0);
        check("mrst_active", bus.active_rx, 1'b0);
        check("mrst_ferr", bus.frame_error, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check("mrst_no_pulse", got_data.size(), 0);
        send_frame(8'h81, 1'b1, t1);
        repeat (5) @(negedge clock);
        expect_frame("post_rst", 8'h81, t1);
        check("post_rst_out", bus.data_rx, 8'h81);

        // Global invariants
        check("never_both", both_cnt, 0);
        check("data_only_on_done", spurious, 0);
        check("ferr_total", ferr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 clock  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 data_rx  output  8  last correctly framed byte; consumed by the bus control stage.
REQ-006 done_rx  output  1  one-cycle pulse: data_rx updated with a new valid byte.
REQ-007 active_rx  output  1  high while a frame is being received (any state except IDLE).
REQ-008 frame_error  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2-cycle latency).
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK, with a 16-bit sample counter and a 3-bit bit index.
REQ-011 IDLE: rx_s low -> START with counter cleared; otherwise remain.
REQ-012 START: counter increments; at count (CLKS_PER_BIT-1)/2 (integer division), rx_s low -> DATA with counter and bit index cleared; rx_s high -> IDLE (glitch rejected, no output pulse).
REQ-013 DATA: counter increments to CLKS_PER_BIT-1, then rx_s is sampled into shift-register bit [bit index] and the counter clears; after bit index 7 -> STOP, otherwise the bit index increments.
REQ-014 STOP: at count CLKS_PER_BIT-1, rx_s high -> data_rx <= shift register, done_rx = 1 for exactly one cycle, -> IDLE.
REQ-015 STOP: at count CLKS_PER_BIT-1, rx_s low -> frame_error = 1 for exactly one cycle, data_rx unchanged, no done_rx, -> BREAK.
REQ-016 BREAK: remain while rx_s low; rx_s high -> IDLE; a line held low SHALL never produce a second frame.
REQ-017 Sampling SHALL occur mid-bit, so a new start edge in the second half of the stop bit is detected from IDLE without loss (back-to-back frames).
REQ-018 done_rx and frame_error SHALL never be asserted in the same cycle; both SHALL be low in all other cycles.
REQ-019 data_rx SHALL hold its value until the next valid frame; it SHALL NOT change on frame errors or rejected starts.
REQ-020 Latency: done_rx SHALL assert 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT cycles (+/-1) after the start-bit falling edge on rx.

Reset
REQ-021 reset SHALL force state IDLE, counter 0, bit index 0, shift register 0x00, data_rx 0x00, done_rx 0, active_rx 0, frame_error 0, and both synchronizer flops to 1.
REQ-022 reset asserted mid-frame SHALL abandon the frame with no output pulse; reception SHALL restart only on a new falling edge after reset is released.

Verification (CLKS_PER_BIT = 16)
REQ-023 Send 0xA5 with a valid stop bit -> one done_rx pulse, data_rx = 0xA5, frame_error never high, active_rx low after the pulse.
REQ-024 Send 0x3C then 0xC3 with no idle gap -> two done_rx pulses, 160 cycles apart, values 0x3C then 0xC3.
REQ-025 Drive rx low for 5 cycles, then high -> no done_rx, no frame_error, FSM back in IDLE, data_rx unchanged.
REQ-026 Send 0x55 with stop bit low, then hold low for 100 cycles, then high -> one frame_error pulse, no done_rx, data_rx retains prior value, no further frame until rx returns high and falls again.
REQ-027 Assert reset during bit 4 of a frame -> all outputs at reset values next cycle; a subsequent frame of 0x81 -> data_rx = 0x81.
